sm3_reg_bank: RTL and testbench

Multi-channel AHB register bank for the SM3 hash accelerator, successor to the single-context register file. Holds CH_NUM independent hash contexts (IV, source/destination address, block size, command), arbitrates pending channels round-robin onto the single SM3 engine, captures results per channel and raises a maskable interrupt. Sits between the AHB slave port and the SM3 engine/DMA front end.

---
 rtl/sm3_reg_bank.sv | 201 ++++++++++++++++++++
 tb/tb_sm3_reg_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_reg_bank.sv
// sm3_reg_bank: AHB register bank holding CH_NUM independent SM3 hash
// contexts. Pending channels are granted round-robin onto the single SM3
// engine, and each channel captures its own result and DONE/interrupt state.
//
// Optional feature macro: SM3_RESULT_CHAIN_EN. When it is defined, the engine
// result also overwrites the IV of the finishing channel, so the next START
// continues a multi-block hash.
//
// Ports:
//   AHB_HCLK, AHB_HRESETN        clock, synchronous active-low reset
//   AHB_HSEL/HWRITE/HADDR/HWDATA AHB slave access (word address)
//   AHB_HRDATA                   registered read data
//   ENABLE                       one-cycle engine start pulse
//   CH_SEL                       channel that owns the engine
//   LAST_RES/SAR_ADDR/DAR_ADDR/BSR/CMDR  context of CH_SEL (IV0 in 255:224)
//   DONE_IN, TEMP_RES            engine completion pulse and result
//   CRYPT_INTR                   OR over channels of (DONE & IE)
module sm3_reg_bank #(
   parameter int CH_NUM = 2,
   parameter int LEN_W  = 13,
   parameter int CH_W   = 3
) (
   input  logic              AHB_HCLK,
   input  logic              AHB_HRESETN,
   input  logic              AHB_HSEL,
   input  logic              AHB_HWRITE,
   input  logic [19:0]       AHB_HADDR,
   input  logic [31:0]       AHB_HWDATA,
   output logic [31:0]       AHB_HRDATA,
   output logic              ENABLE,
   output logic [CH_W-1:0]   CH_SEL,
   output logic [255:0]      LAST_RES,
   output logic [LEN_W-1:0]  SAR_ADDR,
   output logic [LEN_W-1:0]  DAR_ADDR,
   output logic [LEN_W-1:0]  BSR,
   output logic [1:0]        CMDR,
   input  logic              DONE_IN,
   input  logic [255:0]      TEMP_RES,
   output logic              CRYPT_INTR
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   logic [1:0]        state;
   logic [CH_W-1:0]   ch_sel, rr_ptr, grant;
   logic [CH_NUM-1:0] pend, done, ie, busy;
   logic [1:0]        cmd [CH_NUM];
   logic [LEN_W-1:0]  sar [CH_NUM];
   logic [LEN_W-1:0]  dar [CH_NUM];
   logic [LEN_W-1:0]  bsr [CH_NUM];
   // Word k of the packed 256-bit value is IV(7-k) / RES(7-k), so IV0 is the MSW.
   logic [7:0][31:0]  iv  [CH_NUM];
   logic [7:0][31:0]  res [CH_NUM];

   logic [CH_W-1:0]   a_ch;
   logic [4:0]        a_off;
   logic              a_ok, wr_en, rd_en, launch;
   logic [31:0]       rdata;

   assign a_ch   = AHB_HADDR[5+CH_W-1:5];
   assign a_off  = AHB_HADDR[4:0];
   assign a_ok   = (AHB_HADDR[19:5+CH_W] == '0) && (int'(a_ch) < CH_NUM);
   assign wr_en  = AHB_HSEL & AHB_HWRITE & a_ok;
   assign rd_en  = AHB_HSEL & ~AHB_HWRITE;
   assign launch = (state == ST_IDLE) && (|pend);

   assign ENABLE     = (state == ST_LAUNCH);
   assign CH_SEL     = ch_sel;
   assign CRYPT_INTR = |(done & ie);

   // BUSY also acts as the write lock for the channel's context fields.
   always_comb begin
      for (int c = 0; c < CH_NUM; c++)
         busy[c] = pend[c] | ((state != ST_IDLE) && (ch_sel == CH_W'(c)));
   end

   // Round-robin grant: pick the pending channel at the smallest rotated
   // distance from rr_ptr, which points one past the last grant.
   always_comb begin
      int d;
      int best;
      grant = rr_ptr;
      best  = CH_NUM;
      d     = 0;
      for (int j = 0; j < CH_NUM; j++) begin
         d = j - int'(rr_ptr);
         if (d < 0) d = d + CH_NUM;
         if (pend[j] && d < best) begin
            best  = d;
            grant = CH_W'(j);
         end
      end
   end

   // Context of the channel currently owning the engine.
   always_comb begin
      LAST_RES = '0;
      SAR_ADDR = '0;
      DAR_ADDR = '0;
      BSR      = '0;
      CMDR     = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (ch_sel == CH_W'(c)) begin
            LAST_RES = iv[c];
            SAR_ADDR = sar[c];
            DAR_ADDR = dar[c];
            BSR      = bsr[c];
            CMDR     = cmd[c];
         end
      end
   end

   // Read mux; out-of-range channels and unmapped offsets read 0.
   always_comb begin
      rdata = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (a_ok && a_ch == CH_W'(c)) begin
            case (a_off)
               5'd0:    rdata = 32'({cmd[c], ie[c], 1'b0});
               5'd9:    rdata = 32'(sar[c]);
               5'd10:   rdata = 32'(dar[c]);
               5'd11:   rdata = 32'(bsr[c]);
               5'd12:   rdata = 32'({pend[c], done[c], busy[c]});
               default: ;
            endcase
            for (int k = 0; k < 8; k++) begin
               if (a_off == 5'(k + 1))  rdata = iv[c][7-k];
               if (a_off == 5'(k + 16)) rdata = res[c][7-k];
            end
         end
      end
   end

   always_ff @(posedge AHB_HCLK) begin
      if (!AHB_HRESETN) begin
         state      <= ST_IDLE;
         ch_sel     <= '0;
         rr_ptr     <= '0;
         AHB_HRDATA <= '0;
         pend       <= '0;
         done       <= '0;
         ie         <= '0;
         for (int c = 0; c < CH_NUM; c++) begin
            cmd[c] <= '0;
            sar[c] <= '0;
            dar[c] <= '0;
            bsr[c] <= '0;
            iv[c]  <= '0;
            res[c] <= '0;
         end
      end else begin
         if (rd_en) AHB_HRDATA <= rdata;

         case (state)
            ST_IDLE: if (launch) begin
               state  <= ST_LAUNCH;
               ch_sel <= grant;
               rr_ptr <= (grant == CH_W'(CH_NUM - 1)) ? '0 : grant + CH_W'(1);
            end
            ST_LAUNCH: state <= ST_RUN;
            ST_RUN:    if (DONE_IN) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase

         for (int c = 0; c < CH_NUM; c++) begin
            if (wr_en && a_ch == CH_W'(c)) begin
               case (a_off)
                  5'd0: begin
                     ie[c] <= AHB_HWDATA[1];
                     if (!busy[c]) begin
                        cmd[c] <= AHB_HWDATA[3:2];
                        if (AHB_HWDATA[0]) pend[c] <= 1'b1;
                     end
                  end
                  5'd9:    if (!busy[c]) sar[c] <= AHB_HWDATA[LEN_W-1:0];
                  5'd10:   if (!busy[c]) dar[c] <= AHB_HWDATA[LEN_W-1:0];
                  5'd11:   if (!busy[c]) bsr[c] <= AHB_HWDATA[LEN_W-1:0];
                  5'd12:   if (AHB_HWDATA[1]) done[c] <= 1'b0;
                  default: ;
               endcase
               for (int k = 0; k < 8; k++)
                  if (a_off == 5'(k + 1) && !busy[c]) iv[c][7-k] <= AHB_HWDATA;
            end

            // A granted channel is pending, so it cannot also see a START here.
            if (launch && grant == CH_W'(c)) pend[c] <= 1'b0;

            // Completion comes after the W1C so a same-cycle set wins.
            if (state == ST_RUN && DONE_IN && ch_sel == CH_W'(c)) begin
               done[c] <= 1'b1;
               res[c]  <= TEMP_RES;
`ifdef SM3_RESULT_CHAIN_EN
               iv[c]   <= TEMP_RES;
`else
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_sm3_reg_bank.sv
// Directed bench for sm3_reg_bank: read data and engine grants are checked
// through expectation queues filled when the stimulus is driven.
module tb_sm3_reg_bank;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         hsel, hwrite;
   logic [19:0]  haddr;
   logic [31:0]  hwdata, hrdata;
   logic         enable;
   logic [2:0]   ch_sel;
   logic [255:0] last_res;
   logic [12:0]  sar_addr, dar_addr, bsr;
   logic [1:0]   cmdr;
   logic         done_in;
   logic [255:0] temp_res;
   logic         crypt_intr;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_exp_q[$];
   string       rd_tag_q[$];
   logic [2:0]  grant_q[$];

   localparam logic [255:0] TR1 = {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                   32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
   localparam logic [255:0] TR2 = {8{32'hcafe0001}};

   always #5 clk = ~clk;

   sm3_reg_bank #(.CH_NUM(2), .LEN_W(13), .CH_W(3)) dut (
      .AHB_HCLK(clk), .AHB_HRESETN(rst_n), .AHB_HSEL(hsel), .AHB_HWRITE(hwrite),
      .AHB_HADDR(haddr), .AHB_HWDATA(hwdata), .AHB_HRDATA(hrdata),
      .ENABLE(enable), .CH_SEL(ch_sel), .LAST_RES(last_res),
      .SAR_ADDR(sar_addr), .DAR_ADDR(dar_addr), .BSR(bsr), .CMDR(cmdr),
      .DONE_IN(done_in), .TEMP_RES(temp_res), .CRYPT_INTR(crypt_intr)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] addr(input int ch, input int off);
      return 20'(ch * 32 + off);
   endfunction

   task automatic wr(input logic [19:0] a, input logic [31:0] d);
      @(negedge clk);
      hsel = 1'b1; hwrite = 1'b1; haddr = a; hwdata = d;
      @(posedge clk); #1;
      hsel = 1'b0; hwrite = 1'b0;
   endtask

   task automatic rd(input logic [19:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      string       t;
      @(negedge clk);
      hsel = 1'b1; hwrite = 1'b0; haddr = a;
      rd_exp_q.push_back(exp);
      rd_tag_q.push_back(tag);
      @(posedge clk); #1;
      hsel = 1'b0;
      e = rd_exp_q.pop_front();
      t = rd_tag_q.pop_front();
      chk(t, hrdata, e);
   endtask

   task automatic done_pulse(input logic [255:0] r);
      @(negedge clk);
      done_in = 1'b1; temp_res = r;
      @(posedge clk); #1;
      done_in = 1'b0;
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_enable"}, enable, 0);
      chk({tag, "_ch_sel"}, ch_sel, 0);
      chk({tag, "_last_res"}, last_res, 0);
      chk({tag, "_sar"}, sar_addr, 0);
      chk({tag, "_dar"}, dar_addr, 0);
      chk({tag, "_bsr"}, bsr, 0);
      chk({tag, "_cmdr"}, cmdr, 0);
      chk({tag, "_intr"}, crypt_intr, 0);
      chk({tag, "_hrdata"}, hrdata, 0);
   endtask

   // Grant scoreboard: every ENABLE pulse must match the next expected grant.
   always @(posedge clk) begin
      #1;
      if (enable === 1'b1) begin
         chk("grant_expected", 256'(grant_q.size() != 0), 1);
         if (grant_q.size() != 0) chk("grant_ch", ch_sel, grant_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_iv0, exp_iv2;
      rst_n = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
      done_in = 1'b0; temp_res = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      for (int ch = 0; ch < 2; ch++)
         for (int off = 0; off < 24; off++)
            rd(addr(ch, off), 32'h0, $sformatf("rst_rd_ch%0d_off%0d", ch, off));

      // Channel isolation, decode limits, field truncation
      wr(addr(1, 2), 32'hffffffff);
      rd(addr(1, 2), 32'hffffffff, "ch1_iv1");
      rd(addr(0, 2), 32'h0, "ch0_iv1_untouched");
      wr(addr(2, 2), 32'h12345678);
      rd(addr(2, 2), 32'h0, "bad_channel");
      wr(20'h00102, 32'h87654321);
      rd(addr(0, 2), 32'h0, "upper_addr_alias");
      rd(20'h00122, 32'h0, "upper_addr_read");
      wr(addr(1, 11), 32'hffffffff);
      rd(addr(1, 11), 32'h00001fff, "bsr_trunc");

      // Program ch0 and launch
      wr(addr(0, 9), 32'd1);
      wr(addr(0, 10), 32'd16);
      wr(addr(0, 11), 32'h00001000);
      wr(addr(0, 1), 32'ha5a5a5a5);
      wr(addr(0, 0), 32'h6);
      rd(addr(0, 0), 32'h6, "ctrl_rb");
      grant_q.push_back(3'd0);
      wr(addr(0, 0), 32'h7);
      chk("enable_before_launch", enable, 0);
      @(posedge clk); #1;
      chk("enable_launch", enable, 1);
      chk("ch_sel_launch", ch_sel, 0);
      chk("sar_out", sar_addr, 13'd1);
      chk("dar_out", dar_addr, 13'd16);
      chk("bsr_out", bsr, 13'h1000);
      chk("cmdr_out", cmdr, 2'd1);
      chk("last_res_out", last_res, {32'ha5a5a5a5, 224'h0});
      @(posedge clk); #1;
      chk("enable_one_cycle", enable, 0);
      rd(addr(0, 12), 32'h1, "status_busy");
      wr(addr(0, 9), 32'd5);
      rd(addr(0, 9), 32'd1, "sar_locked");
      wr(addr(0, 0), 32'h0);
      rd(addr(0, 0), 32'h4, "ie_writable_cmd_locked");
      wr(addr(0, 0), 32'h6);

      // Completion
      done_pulse(TR1);
      chk("intr_set", crypt_intr, 1);
      rd(addr(0, 17), 32'h11111111, "res1");
      rd(addr(0, 23), 32'h77777777, "res7");
      rd(addr(0, 16), 32'h0, "res0");
      rd(addr(0, 12), 32'h2, "status_done");
`ifdef SM3_RESULT_CHAIN_EN
      exp_iv0 = 32'h0;
      exp_iv2 = 32'h22222222;
`else
      exp_iv0 = 32'ha5a5a5a5;
      exp_iv2 = 32'h0;
`endif
      rd(addr(0, 1), exp_iv0, "iv0_after_done");
      rd(addr(0, 3), exp_iv2, "iv2_after_done");
      wr(addr(0, 12), 32'h2);
      chk("intr_cleared", crypt_intr, 0);
      rd(addr(0, 12), 32'h0, "status_cleared");

      // Round-robin: ch0 rerun, ch1 queued behind it, then ch0 again
      grant_q.push_back(3'd0);
      wr(addr(0, 0), 32'h7);
      grant_q.push_back(3'd1);
      wr(addr(1, 0), 32'h3);
      wr(addr(1, 0), 32'h3);
      wr(addr(1, 1), 32'hdeadbeef);
      rd(addr(1, 1), 32'h0, "iv_write_while_pend");
      rd(addr(1, 12), 32'h5, "ch1_status_pend");
      rd(addr(0, 12), 32'h1, "ch0_status_run");
      done_pulse(TR2);
      repeat (3) @(posedge clk);
      #1;
      rd(addr(0, 12), 32'h2, "ch0_status_done");
      rd(addr(1, 12), 32'h1, "ch1_status_run");
      grant_q.push_back(3'd0);
      wr(addr(0, 0), 32'h7);
      rd(addr(0, 12), 32'h7, "ch0_pend_keeps_done");
      done_pulse(TR1);
      repeat (3) @(posedge clk);
      #1;
      rd(addr(1, 17), 32'h11111111, "ch1_res1");
      rd(addr(0, 17), 32'hcafe0001, "ch0_res1");

      // DONE_IN and DONE W1C at the same edge: set wins
      @(negedge clk);
      done_in = 1'b1; temp_res = TR2;
      hsel = 1'b1; hwrite = 1'b1; haddr = addr(0, 12); hwdata = 32'h2;
      @(posedge clk); #1;
      done_in = 1'b0; hsel = 1'b0; hwrite = 1'b0;
      rd(addr(0, 12), 32'h2, "done_set_wins");
      chk("grants_drained", grant_q.size(), 0);

      // Reset during RUN, then a late DONE_IN
      grant_q.push_back(3'd0);
      wr(addr(0, 0), 32'h7);
      repeat (2) @(posedge clk);
      #1;
      rd(addr(0, 9), 32'd1, "sar_during_run");
      chk("intr_before_reset", crypt_intr, 1);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      chk_outs_zero("reset_in_run");
      @(negedge clk) rst_n = 1'b1;
      done_pulse(TR1);
      rd(addr(0, 17), 32'h0, "late_done_res");
      rd(addr(0, 12), 32'h0, "late_done_status");
      chk("late_done_intr", crypt_intr, 0);

      // Engine still usable after reset
      grant_q.push_back(3'd1);
      wr(addr(1, 0), 32'h1);
      repeat (3) @(posedge clk);
      #1;
      done_pulse(TR2);
      rd(addr(1, 12), 32'h2, "post_reset_done");
      chk("grants_final", grant_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
